// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: button FSM states,
// default timing parameters and the width of the debounced switch bus.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CNT   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CNT = 2'd3
  } btn_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int SW_BUS_W                = 8;

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Multi-bit flip-flop synchronizer with a per-instance reset value.
// Each bit is an independent chain; the bus is not treated as coherent.
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift the raw input through DEPTH flops; clear loads the idle value.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= rst_val;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/input_conditioner.sv
// Debounces an active-low pushbutton into a single advance pulse and an
// 8-bit switch bus {Din, MS, level} into stable values with a change pulse.
// Both paths run in parallel and end in one common output register, so a
// button pulse and a switch update triggered together appear together.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       next_raw,
  input  logic [3:0] Din_raw,
  input  logic [2:0] MS_raw,
  input  logic       level_raw,
  output logic       next_pulse,
  output logic [3:0] Din,
  output logic [2:0] MS,
  output logic       level,
  output logic       sw_change
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic                btn_sync_s;
  logic                pressed_s;
  logic [SW_BUS_W-1:0] sw_sync_s;

  btn_state_e          btn_state_r, btn_state_s;
  logic [CNT_W-1:0]    btn_cnt_r, btn_cnt_s;
  logic                fire_r, fire_s;

  logic [SW_BUS_W-1:0] cand_r;
  logic [SW_BUS_W-1:0] stable_r;
  logic [CNT_W-1:0]    sw_cnt_r;
  logic                sw_chg_r;

  // Button idles high (released), switches idle low.
  sync_chain #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_btn_sync (
    .clk     (clk),
    .clear   (clear),
    .rst_val (1'b1),
    .d       (next_raw),
    .q       (btn_sync_s)
  );

  sync_chain #(.WIDTH(SW_BUS_W), .DEPTH(SYNC_STAGES)) u_sw_sync (
    .clk     (clk),
    .clear   (clear),
    .rst_val ({SW_BUS_W{1'b0}}),
    .d       ({Din_raw, MS_raw, level_raw}),
    .q       (sw_sync_s)
  );

  assign pressed_s = ~btn_sync_s;

  // Button FSM next state: fire once on accepted press, never on release.
  always_comb begin
    btn_state_s = btn_state_r;
    btn_cnt_s   = btn_cnt_r;
    fire_s      = 1'b0;
    case (btn_state_r)
      IDLE: begin
        if (pressed_s) begin
          btn_state_s = PRESS_CNT;
          btn_cnt_s   = {CNT_W{1'b0}};
        end else begin
          btn_state_s = IDLE;
        end
      end
      PRESS_CNT: begin
        if (!pressed_s) begin
          btn_state_s = IDLE;
          btn_cnt_s   = {CNT_W{1'b0}};
        end else if (btn_cnt_r == CNT_LAST) begin
          btn_state_s = HELD;
          fire_s      = 1'b1;
        end else begin
          btn_cnt_s   = sat_inc(btn_cnt_r);
        end
      end
      HELD: begin
        if (!pressed_s) begin
          btn_state_s = RELEASE_CNT;
          btn_cnt_s   = {CNT_W{1'b0}};
        end else begin
          btn_state_s = HELD;
        end
      end
      RELEASE_CNT: begin
        if (pressed_s) begin
          // A bounce during release returns to HELD silently.
          btn_state_s = HELD;
          btn_cnt_s   = {CNT_W{1'b0}};
        end else if (btn_cnt_r == CNT_LAST) begin
          btn_state_s = IDLE;
          btn_cnt_s   = {CNT_W{1'b0}};
        end else begin
          btn_cnt_s   = sat_inc(btn_cnt_r);
        end
      end
      default: begin
        btn_state_s = IDLE;
        btn_cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Button FSM state, counter and internal fire strobe.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      btn_state_r <= IDLE;
      btn_cnt_r   <= {CNT_W{1'b0}};
      fire_r      <= 1'b0;
    end else begin
      btn_state_r <= btn_state_s;
      btn_cnt_r   <= btn_cnt_s;
      fire_r      <= fire_s;
    end
  end

  // Switch bus debounce: reload candidate on mismatch, accept after a full run of matches.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cand_r   <= {SW_BUS_W{1'b0}};
      stable_r <= {SW_BUS_W{1'b0}};
      sw_cnt_r <= {CNT_W{1'b0}};
      sw_chg_r <= 1'b0;
    end else if (sw_sync_s != cand_r) begin
      cand_r   <= sw_sync_s;
      sw_cnt_r <= {CNT_W{1'b0}};
      sw_chg_r <= 1'b0;
    end else begin
      sw_cnt_r <= sat_inc(sw_cnt_r);
      if (sw_cnt_r == CNT_LAST) begin
        stable_r <= cand_r;
        sw_chg_r <= (cand_r != stable_r);
      end else begin
        sw_chg_r <= 1'b0;
      end
    end
  end

  // Common output register so both paths share one latency.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      next_pulse <= 1'b0;
      sw_change  <= 1'b0;
      Din        <= 4'h0;
      MS         <= 3'h0;
      level      <= 1'b0;
    end else begin
      next_pulse <= fire_r;
      sw_change  <= sw_chg_r;
      {Din, MS, level} <= stable_r;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// Pulses appear 11 cycles after the first edge that samples a new raw value.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       clear;
  logic       next_raw;
  logic [3:0] Din_raw;
  logic [2:0] MS_raw;
  logic       level_raw;
  logic       next_pulse;
  logic [3:0] Din;
  logic [2:0] MS;
  logic       level;
  logic       sw_change;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulse_cnt = 0, last_pulse = -1;
  int swc_cnt   = 0, last_swc   = -1;
  int e0, p0, s0;

  localparam int LAT = 11;

  input_conditioner #(.DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .clear      (clear),
    .next_raw   (next_raw),
    .Din_raw    (Din_raw),
    .MS_raw     (MS_raw),
    .level_raw  (level_raw),
    .next_pulse (next_pulse),
    .Din        (Din),
    .MS         (MS),
    .level      (level),
    .sw_change  (sw_change)
  );

  always #5 clk = ~clk;

  // Edge counter: cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (next_pulse) begin
      pulse_cnt++;
      last_pulse = cyc;
    end
    if (sw_change) begin
      swc_cnt++;
      last_swc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; next_raw = 1'b1; Din_raw = 4'h0; MS_raw = 3'h0; level_raw = 1'b0;
    wait_cycles(3);
    check_eq("rst_next_pulse", next_pulse, 1'b0);
    check_eq("rst_sw_change", sw_change, 1'b0);
    check_eq("rst_Din", Din, 4'h0);
    check_eq("rst_MS", MS, 3'h0);
    check_eq("rst_level", level, 1'b0);
    clear = 1'b0;
    wait_cycles(4);

    // Clean press held 20 cycles: one pulse at +11, nothing on release.
    p0 = pulse_cnt; next_raw = 1'b0; e0 = cyc + 1;
    wait_cycles(20);
    check_eq("press_count", pulse_cnt - p0, 1);
    check_eq("press_latency", last_pulse, e0 + LAT);
    next_raw = 1'b1;
    wait_cycles(15);
    check_eq("release_no_pulse", pulse_cnt - p0, 1);

    // 5-cycle glitch: no pulse, and the FSM is back in IDLE (full latency next press).
    p0 = pulse_cnt; next_raw = 1'b0;
    wait_cycles(5);
    next_raw = 1'b1;
    wait_cycles(15);
    check_eq("glitch_no_pulse", pulse_cnt - p0, 0);
    p0 = pulse_cnt; next_raw = 1'b0; e0 = cyc + 1;
    wait_cycles(14);
    check_eq("after_glitch_count", pulse_cnt - p0, 1);
    check_eq("after_glitch_latency", last_pulse, e0 + LAT);
    next_raw = 1'b1;
    wait_cycles(12);

    // Release bounce then re-press: no second pulse; clean release then press: pulse.
    next_raw = 1'b0;
    wait_cycles(14);
    p0 = pulse_cnt; next_raw = 1'b1;
    wait_cycles(3);
    next_raw = 1'b0;
    wait_cycles(10);
    check_eq("bounce_no_pulse", pulse_cnt - p0, 0);
    next_raw = 1'b1;
    wait_cycles(12);
    check_eq("clean_release_no_pulse", pulse_cnt - p0, 0);
    next_raw = 1'b0; e0 = cyc + 1;
    wait_cycles(14);
    check_eq("second_press_count", pulse_cnt - p0, 1);
    check_eq("second_press_latency", last_pulse, e0 + LAT);
    next_raw = 1'b1;
    wait_cycles(12);

    // Din 0 -> A stable: update and one sw_change at +11.
    s0 = swc_cnt; Din_raw = 4'hA; e0 = cyc + 1;
    wait_cycles(12);
    check_eq("din_value", Din, 4'hA);
    check_eq("din_swc_count", swc_cnt - s0, 1);
    check_eq("din_swc_latency", last_swc, e0 + LAT);

    // Toggling every 4 cycles never settles; ending on A reloads the same value silently.
    for (int i = 0; i < 6; i++) begin
      Din_raw = (i % 2 == 0) ? 4'h5 : 4'hA;
      wait_cycles(4);
      check_eq("toggle_din_hold", Din, 4'hA);
    end
    wait_cycles(12);
    check_eq("toggle_din_final", Din, 4'hA);
    check_eq("toggle_no_swc", swc_cnt - s0, 1);

    // Level switch.
    level_raw = 1'b1;
    wait_cycles(12);
    check_eq("level_value", level, 1'b1);
    check_eq("level_keeps_din", Din, 4'hA);

    // Clear during PRESS_CNT (count 5): outputs drop at once, no pulse; re-debounce after.
    p0 = pulse_cnt; next_raw = 1'b0;
    wait_cycles(8);
    clear = 1'b1;
    #1;
    check_eq("clr_Din", Din, 4'h0);
    check_eq("clr_level", level, 1'b0);
    check_eq("clr_MS", MS, 3'h0);
    check_eq("clr_next_pulse", next_pulse, 1'b0);
    check_eq("clr_sw_change", sw_change, 1'b0);
    wait_cycles(3);
    check_eq("clr_abort_no_pulse", pulse_cnt - p0, 0);
    clear = 1'b0; e0 = cyc + 1;
    wait_cycles(14);
    check_eq("clr_repress_count", pulse_cnt - p0, 1);
    check_eq("clr_repress_latency", last_pulse, e0 + LAT);
    check_eq("clr_din_restored", Din, 4'hA);
    next_raw = 1'b1;
    wait_cycles(12);

    // Simultaneous press and MS change: both pulses in the same cycle.
    p0 = pulse_cnt; s0 = swc_cnt;
    next_raw = 1'b0; MS_raw = 3'b101; e0 = cyc + 1;
    wait_cycles(14);
    check_eq("simul_pulse_count", pulse_cnt - p0, 1);
    check_eq("simul_swc_count", swc_cnt - s0, 1);
    check_eq("simul_pulse_latency", last_pulse, e0 + LAT);
    check_eq("simul_swc_latency", last_swc, e0 + LAT);
    check_eq("simul_MS", MS, 3'd5);
    next_raw = 1'b1;
    wait_cycles(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
